// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the fifo write-port arbiter.
//   arb_state_t : arbiter FSM encoding (idle / burst ownership)
//   STAT_W      : width of each statistics counter
//   rr_next     : reference round-robin index, scanning upward from last+1
//                 with wrap; returns -1 when no request is set
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    localparam int STAT_W = 32;

    // First set bit of req at or after last+1, wrapping at n-1 -> 0.
    function automatic int rr_next(input logic [15:0] req, input int last, input int n = 16);
        int idx;
        rr_next = -1;
        for (int k = 1; k <= 16; k++) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (rr_next < 0 && req[idx[3:0]]) begin
                    rr_next = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_arb_rr_pick
// Combinational round-robin picker: rotate the request vector so that the
// slot after last sits at bit 0, priority-encode the lowest set bit, then
// un-rotate the offset back into an absolute index.
// Ports:
//   req   in  NUM_REQ  request vector
//   last  in  ID_W     previous owner (search starts at last+1)
//   found out 1        at least one request is set
//   idx   out ID_W     selected requester (meaningful only when found)
// ---------------------------------------------------------------------------
module fifo_arb_rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0]    start_idx;
    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;

    // Modular add that stays correct for non-power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    assign start_idx = wrap_add(last, 1);

    // Rotate so that the highest-priority candidate lands on bit 0.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot[k] = req[wrap_add(start_idx, k)];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k[ID_W-1:0];
            end
        end
    end

    assign found = |rot;
    assign idx   = wrap_add(start_idx, int'(off));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares one fifo write port among NUM_REQ producers using round-robin burst
// arbitration. A granted producer owns the port for up to MAX_BURST accepted
// beats; pushes are gated by fifo_pre_full so no beat is lost. Each grant is
// preceded by one idle bubble cycle. The data path is combinational.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   req_valid      per-producer beat available
//   req_data       producer i beat at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      per-producer accept strobe
//   fifo_pre_full  fifo cannot take a write this cycle
//   fifo_w_valid   push strobe to the fifo
//   fifo_data_in   push data to the fifo (0 while idle)
//   grant_active   arbiter is in a burst
//   grant_id       current / last owner
// Optional build macro FIFO_ARB_STATS_EN adds:
//   stat_beats     per-producer accepted-beat counters (NUM_REQ*STAT_W)
//   stat_stall     count of burst cycles with a valid owner blocked by pre_full
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  MAX_BURST  = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_pre_full,
    output logic                          fifo_w_valid,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_active,
    output logic [ID_W-1:0]               grant_id
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     stat_beats,
    output logic [STAT_W-1:0]             stat_stall
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    arb_state_t       state_nx;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] beat_cnt;
    logic             owner_valid;
    logic             accept;
    logic             burst_done;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_valid = req_valid[grant_id];
    assign accept      = (state == ARB_BURST) && owner_valid && !fifo_pre_full;

    // A burst ends on its final accepted beat, or as soon as the owner goes
    // idle (it forfeits the rest of its allowance). A stall keeps the grant.
    assign burst_done  = (state == ARB_BURST) &&
                         (!owner_valid || (accept && beat_cnt == CNT_W'(MAX_BURST - 1)));

    // State register; reset drops any grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: idle grants whenever anyone requests, burst runs to done.
    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE:  if (pick_found) state_nx = ARB_BURST;
            ARB_BURST: if (burst_done) state_nx = ARB_IDLE;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    // Grant bookkeeping: owner captured on grant, beat count per burst,
    // and last owner recorded on release to seed the next round-robin scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            if (state == ARB_IDLE && pick_found) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (burst_done) begin
                last_grant <= grant_id;
            end
        end
    end

    // Outputs: only the owner sees ready, data muxed straight through.
    always_comb begin
        req_ready    = '0;
        fifo_w_valid = 1'b0;
        fifo_data_in = '0;
        grant_active = (state == ARB_BURST);
        if (state == ARB_BURST) begin
            req_ready[grant_id] = owner_valid && !fifo_pre_full;
            fifo_w_valid        = accept;
            fifo_data_in        = req_data[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Statistics: wrapping counters of accepted beats per producer and of
    // cycles where the owner was held off by a full fifo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (accept) begin
                stat_beats[int'(grant_id) * STAT_W +: STAT_W] <=
                    stat_beats[int'(grant_id) * STAT_W +: STAT_W] + 1'b1;
            end
            if (state == ARB_BURST && owner_valid && fifo_pre_full) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed and random bench for fifo_wr_arbiter with a behavioural depth-4
// fifo behind it. Producer i presents {i[7:0], 8'h00, seq_i} and advances
// seq_i on each accepted beat, so fifo output reveals owner and order.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = 4'h0;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_pre_full;
    logic         fifo_w_valid;
    logic [31:0]  fifo_data_in;
    logic         grant_active;
    logic [1:0]   grant_id;
`ifdef FIFO_ARB_STATS_EN
    logic [127:0] stat_beats;
    logic [31:0]  stat_stall;
`endif

    logic         cons_ready = 1'b1;
    logic         manual_data = 1'b0;
    logic [31:0]  man_data [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [15:0]  seq [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
    logic [31:0]  fifo_q [$];
    logic [31:0]  push_log [$];
    logic [31:0]  popped [$];
    int           fifo_cnt = 0;
    int           push_count = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .MAX_BURST  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_pre_full (fifo_pre_full),
        .fifo_w_valid  (fifo_w_valid),
        .fifo_data_in  (fifo_data_in),
        .grant_active  (grant_active),
        .grant_id      (grant_id)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_beats    (stat_beats),
        .stat_stall    (stat_stall)
`endif
    );

    // Producer data: tagged sequence numbers, or hand-set words.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*32 +: 32] = manual_data ? man_data[i] : {8'(i), 8'h00, seq[i]};
        end
    end

    // Producers advance their sequence only on an accepted beat.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) seq[i] <= seq[i] + 16'd1;
        end
    end

    // Depth-4 fifo model; pre_full is registered occupancy reaching depth.
    always @(posedge clk) begin
        if (reset) begin
            fifo_q.delete();
            push_log.delete();
            popped.delete();
            push_count = 0;
            fifo_cnt <= 0;
        end else begin
            if (cons_ready && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
            if (fifo_w_valid) begin
                fifo_q.push_back(fifo_data_in);
                push_log.push_back(fifo_data_in);
                push_count++;
            end
            fifo_cnt <= fifo_q.size();
        end
    end

    assign fifo_pre_full = (fifo_cnt >= 4);

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 4'h0;
        cons_ready = 1'b1;
        manual_data = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (grant_active !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'h0 ||
            fifo_w_valid !== 1'b0 || fifo_data_in !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got ga=%0b id=%0d rdy=%0h wv=%0b d=%0h expected 0 0 0 0 0",
                     grant_active, grant_id, req_ready, fifo_w_valid, fifo_data_in);
        end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (grant_active !== 1'b1 || grant_id !== 2'd0) begin
                    errors++;
                    $display("FAIL reset_first_grant got ga=%0b id=%0d expected 1 0", grant_active, grant_id);
                end
            end
            if (c == 2) begin
                checks++;
                if (fifo_w_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_pre_push got %0b expected 1", fifo_w_valid);
                end
            end
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_active !== 1'b0 || req_ready !== 4'h0 || fifo_w_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst got ga=%0b rdy=%0h wv=%0b expected 0 0 0",
                     grant_active, req_ready, fifo_w_valid);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (grant_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_bubble got %0b expected 0", grant_active);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant_active !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_regrant got ga=%0b id=%0d expected 1 0", grant_active, grant_id);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int gid;
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c % 5 == 0) begin
                checks++;
                if (grant_active !== 1'b0 || fifo_w_valid !== 1'b0 || req_ready !== 4'h0 ||
                    fifo_data_in !== 32'h0) begin
                    errors++;
                    $display("FAIL rr_idle c=%0d got ga=%0b wv=%0b rdy=%0h d=%0h expected 0 0 0 0",
                             c, grant_active, fifo_w_valid, req_ready, fifo_data_in);
                end
            end else begin
                gid = (c / 5) % 4;
                exp_rdy = 4'b0001 << gid;
                checks++;
                if (grant_active !== 1'b1 || grant_id !== 2'(gid)) begin
                    errors++;
                    $display("FAIL rr_grant c=%0d got ga=%0b id=%0d expected 1 %0d", c, grant_active, grant_id, gid);
                end
                checks++;
                if (fifo_w_valid !== 1'b1 || req_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL rr_push c=%0d got wv=%0b rdy=%0h expected 1 %0h", c, fifo_w_valid, req_ready, exp_rdy);
                end
                checks++;
                if (fifo_data_in[31:24] !== 8'(gid)) begin
                    errors++;
                    $display("FAIL rr_data c=%0d got tag %0d expected %0d", c, fifo_data_in[31:24], gid);
                end
            end
            next_cycle();
        end
        checks++;
        if (push_log.size() != 20) begin
            errors++;
            $display("FAIL rr_beats got %0d expected 20", push_log.size());
        end
    endtask

    task automatic test_early_release();
        int n1;
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            if (c == 8) req_valid = 4'b1101;
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if (grant_active !== 1'b1 || grant_id !== 2'd1 || fifo_w_valid !== 1'b0 || req_ready !== 4'h0) begin
                    errors++;
                    $display("FAIL early_drop got ga=%0b id=%0d wv=%0b rdy=%0h expected 1 1 0 0",
                             grant_active, grant_id, fifo_w_valid, req_ready);
                end
            end
            if (c == 9) begin
                checks++;
                if (grant_active !== 1'b0) begin
                    errors++;
                    $display("FAIL early_bubble got %0b expected 0", grant_active);
                end
            end
            if (c == 10) begin
                checks++;
                if (grant_active !== 1'b1 || grant_id !== 2'd2) begin
                    errors++;
                    $display("FAIL early_next got ga=%0b id=%0d expected 1 2", grant_active, grant_id);
                end
            end
            next_cycle();
        end
        n1 = 0;
        foreach (push_log[k]) if (push_log[k][31:24] == 8'd1) n1++;
        checks++;
        if (n1 != 2) begin
            errors++;
            $display("FAIL early_beats got %0d expected 2", n1);
        end
        checks++;
        if (push_log.size() != 8 || push_log[6][31:24] !== 8'd2) begin
            errors++;
            $display("FAIL early_order got size=%0d tag6=%0d expected 8 2", push_log.size(), push_log[6][31:24]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_tag;
        do_reset();
        cons_ready = 1'b0;
        req_valid = 4'b1000;
        for (int c = 0; c < 15; c++) begin
            if (c == 5) req_valid = 4'b0001;
            if (c == 9) cons_ready = 1'b1;
            @(negedge clk);
            if (c >= 6 && c <= 9) begin
                checks++;
                if (grant_active !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'h0 || fifo_w_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stall c=%0d got ga=%0b id=%0d rdy=%0h wv=%0b expected 1 0 0 0",
                             c, grant_active, grant_id, req_ready, fifo_w_valid);
                end
            end
            if (c == 10) begin
                checks++;
                if (fifo_w_valid !== 1'b1 || req_ready !== 4'b0001) begin
                    errors++;
                    $display("FAIL bp_resume got wv=%0b rdy=%0h expected 1 1", fifo_w_valid, req_ready);
                end
            end
            if (c == 14) begin
                checks++;
                if (grant_active !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_release got %0b expected 0", grant_active);
                end
`ifdef FIFO_ARB_STATS_EN
                checks++;
                if (stat_stall !== 32'd4) begin
                    errors++;
                    $display("FAIL bp_stat_stall got %0d expected 4", stat_stall);
                end
`endif
            end
            next_cycle();
        end
        req_valid = 4'h0;
        checks++;
        if (push_log.size() != 8) begin
            errors++;
            $display("FAIL bp_count got %0d expected 8", push_log.size());
        end
        for (int k = 0; k < 8; k++) begin
            exp_tag = (k < 4) ? 8'd3 : 8'd0;
            checks++;
            if (push_log[k][31:24] !== exp_tag) begin
                errors++;
                $display("FAIL bp_tag k=%0d got %0d expected %0d", k, push_log[k][31:24], exp_tag);
            end
        end
        for (int k = 5; k < 8; k++) begin
            checks++;
            if (push_log[k][15:0] !== push_log[4][15:0] + 16'(k - 4)) begin
                errors++;
                $display("FAIL bp_seq k=%0d got %0h expected %0h", k, push_log[k][15:0], push_log[4][15:0] + 16'(k - 4));
            end
        end
    endtask

    task automatic test_sparse();
        do_reset();
        manual_data = 1'b1;
        man_data[3] = 32'hA5A5_0001;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) req_valid = 4'b1000;
            if (c == 2) req_valid = 4'b0000;
            if (c == 3) begin
                man_data[3] = 32'hA5A5_0002;
                req_valid = 4'b1000;
            end
            if (c == 5) req_valid = 4'b0000;
            @(negedge clk);
            if (c == 1 || c == 4) begin
                checks++;
                if (grant_active !== 1'b1 || grant_id !== 2'd3 || fifo_w_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL sparse_grant c=%0d got ga=%0b id=%0d wv=%0b expected 1 3 1",
                             c, grant_active, grant_id, fifo_w_valid);
                end
            end
            if (c == 3) begin
                checks++;
                if (grant_active !== 1'b0) begin
                    errors++;
                    $display("FAIL sparse_release got %0b expected 0", grant_active);
                end
            end
            next_cycle();
        end
        checks++;
        if (push_log.size() != 2 || push_log[0] !== 32'hA5A5_0001 || push_log[1] !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL sparse_data got n=%0d %0h %0h expected 2 a5a50001 a5a50002",
                     push_log.size(), push_log[0], push_log[1]);
        end
        manual_data = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] exp_seq [4];
        logic [31:0] d;
        int id;
        int pops;
        longint unsigned sum;
        do_reset();
        for (int i = 0; i < 4; i++) exp_seq[i] = seq[i];
        pops = 0;
        for (int c = 0; c < 2020; c++) begin
            if (c < 2000) begin
                req_valid = 4'($urandom_range(0, 15));
                cons_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req_valid = 4'h0;
                cons_ready = 1'b1;
            end
            next_cycle();
            while (popped.size() > 0) begin
                d = popped.pop_front();
                pops++;
                id = int'(d[31:24]);
                checks++;
                if (id > 3) begin
                    errors++;
                    $display("FAIL rand_tag got %0h expected tag below 4", d);
                end else if (d[15:0] !== exp_seq[id]) begin
                    errors++;
                    $display("FAIL rand_order p%0d got %0h expected %0h", id, d[15:0], exp_seq[id]);
                    exp_seq[id] = d[15:0] + 16'd1;
                end else begin
                    exp_seq[id] = exp_seq[id] + 16'd1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (exp_seq[i] !== seq[i]) begin
                errors++;
                $display("FAIL rand_lost p%0d got %0h expected %0h", i, exp_seq[i], seq[i]);
            end
        end
        checks++;
        if (pops != push_count || push_count < 200) begin
            errors++;
            $display("FAIL rand_count got pops=%0d pushes=%0d expected equal and at least 200", pops, push_count);
        end
`ifdef FIFO_ARB_STATS_EN
        sum = 0;
        for (int i = 0; i < 4; i++) sum += stat_beats[i*32 +: 32];
        checks++;
        if (sum != longint'(push_count)) begin
            errors++;
            $display("FAIL rand_stat_beats got %0d expected %0d", sum, push_count);
        end
`else
        sum = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_early_release();
        test_backpressure();
        test_sparse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
